// File: rtl/sine_arb_pkg.sv
// rtl/sine_arb_pkg.sv - shared constants and tag type for the sine ROM arbiter
package sine_arb_pkg;

  localparam int DEF_ADDRW = 6;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_NREQ  = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_NREQ-1:0] id;
  } sine_arb_tag_t;

endpackage

// File: rtl/sine_arb_rr_pick.sv
// rtl/sine_arb_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module sine_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int PTRW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] rr_ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  // Walk priorities rr_ptr, rr_ptr+1, ... (mod NREQ) and keep the first set request
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req[i] && (i == ((int'(rr_ptr) + k) % NREQ))) begin
          win[i] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sine_rom_arbiter.sv
// rtl/sine_rom_arbiter.sv - round-robin sharing of one sine ROM; SINE_ARB_RSP_REG_EN adds an output register
module sine_rom_arbiter
  import sine_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDRW   = DEF_ADDRW,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  output logic [NREQ-1:0]       gnt,
  output logic                  rom_en,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] r_rr_ptr;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_win;
  logic            w_any;
  logic [PTRW-1:0] w_idx;
  logic [PTRW-1:0] w_ptr_nxt;
  sine_arb_tag_t   w_tag_in;
  sine_arb_tag_t   r_tag [ROM_LAT];
  sine_arb_tag_t   w_last;
  logic            w_unused_id;

  // Requests are ignored while reset is held so no grant leaks out
  assign w_req = rst_n ? req : '0;

  sine_arb_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req    (w_req),
    .rr_ptr (r_rr_ptr),
    .win    (w_win),
    .any    (w_any)
  );

  assign gnt    = w_win;
  assign rom_en = w_any;

  // Encode the winner, mux its address to the ROM and build the tag entering the pipeline
  always_comb begin
    w_idx    = '0;
    rom_addr = '0;
    w_tag_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_idx    = PTRW'(i);
        rom_addr = req_addr[i*ADDRW +: ADDRW];
      end
    end
    w_tag_in.valid          = w_any;
    w_tag_in.id[NREQ-1:0]   = w_win;
  end

  assign w_ptr_nxt = (w_idx == PTRW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // Priority moves to the slot after the winner; holds when nothing is granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Tag shift register tracks which requester owns the ROM data ROM_LAT cycles later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_last      = r_tag[ROM_LAT-1];
  assign w_unused_id = ^w_last.id;

`ifdef SINE_ARB_RSP_REG_EN
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;

  // Extra output stage: response leaves fully registered one cycle after the tag pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_last.valid ? w_last.id[NREQ-1:0] : '0;
      r_rsp_data  <= w_last.valid ? rom_data : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`else
  // Gating with rst_n drops in-flight reads the moment reset is asserted
  assign rsp_valid = (rst_n && w_last.valid) ? w_last.id[NREQ-1:0] : '0;
  assign rsp_data  = (rst_n && w_last.valid) ? rom_data : '0;
`endif

endmodule
